// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: requester/state encoding and default widths.
package mem_arb_pkg;
  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned MAX_DATA_RUN_DEF = 4;
  localparam int unsigned RUN_W            = 4;

  // Doubles as the id of the requester granted in the previous cycle.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LD   = 2'd1,
    ARB_DM   = 2'd2,
    ARB_IF   = 2'd3
  } arb_state_e;
endpackage

// File: rtl/arb_run_counter.sv
// Saturating count of data grants made while a fetch is left waiting.
module arb_run_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [RUN_W-1:0] cnt_o
);
  logic [RUN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: loader > data > fetch, one grant per cycle, 1-cycle ready.
// Define ARB_FAIRNESS_EN to let fetch preempt data after MAX_DATA_RUN consecutive data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15) begin : g_bad_run
    $error("MAX_DATA_RUN must be in 1..15");
  end

  arb_state_e        state_q, state_d;
  logic              dm_was_rd_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              ld_el, dm_el, if_el, fair_force;

  // Ready is simply "you won last cycle"; the winner is ineligible while its req is stale.
  assign ld_ready = (state_q == ARB_LD);
  assign dm_ready = (state_q == ARB_DM);
  assign if_ready = (state_q == ARB_IF);

  assign ld_el = ld_wr & ~ld_ready;
  assign dm_el = (dm_rd | dm_wr) & ~dm_ready;
  assign if_el = if_req & ~if_ready;

  assign stall_if = if_req & ~if_ready;
  assign stall_dm = (dm_rd | dm_wr) & ~dm_ready;

`ifdef ARB_FAIRNESS_EN
  logic [RUN_W-1:0] run_cnt;

  arb_run_counter u_run (
    .clk   (clk),
    .Reset (Reset),
    .clr_i (~if_req | (state_d == ARB_IF)),
    .inc_i ((state_d == ARB_DM) & if_el),
    .cnt_o (run_cnt)
  );

  assign fair_force = (run_cnt == RUN_W'(MAX_DATA_RUN)) & if_el;
`else
  assign fair_force = 1'b0;
`endif

  always_comb begin
    state_d   = ARB_IDLE;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!Reset) begin
      if (ld_el)           state_d = ARB_LD;
      else if (fair_force) state_d = ARB_IF;
      else if (dm_el)      state_d = ARB_DM;
      else if (if_el)      state_d = ARB_IF;
    end
    case (state_d)
      ARB_LD: begin
        mem_wr    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      ARB_DM: begin
        // rd+wr together is a write
        mem_wr    = dm_wr;
        mem_rd    = ~dm_wr;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      ARB_IF: begin
        mem_rd   = 1'b1;
        mem_addr = if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ARB_IDLE;
      dm_was_rd_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ARB_DM)       dm_was_rd_q <= ~dm_wr;
      if (if_ready)                if_rdata_q  <= mem_rdata;
      if (dm_ready && dm_was_rd_q) dm_rdata_q  <= mem_rdata;
    end
  end

  assign if_rdata = if_ready ? mem_rdata : if_rdata_q;
  assign dm_rdata = (dm_ready & dm_was_rd_q) ? mem_rdata : dm_rdata_q;
endmodule
